imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//  Owns the single port of the instruction memory. Shares it between three users:
//  - the fetch stage (reads every cycle)
//  - the host program loader (writes)
//  - the debug read port (single reads)
//  Sequences a program load: holds the CPU, streams the words in, then restarts fetch from PC 0.
// PARAMETERS
//  ADDR_W   16    memory address width
//  DATA_W   16    instruction width
//  DEPTH    4096  implemented words; writes at addr >= DEPTH are dropped
//  TIMEOUT  1024  idle cycles in LOAD before the load is aborted
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  fetch_addr   in   ADDR_W  PC requested by the fetch stage
//  fetch_inst   out  DATA_W  mem_rdata, passed through unregistered
//  fetch_stall  out  1       fetch request not served this cycle; fetch must hold its PC
//  ld_valid     in   1       loader word valid
//  ld_ready     out  1       loader word accepted when ld_valid & ld_ready
//  ld_addr      in   ADDR_W  loader word address
//  ld_data      in   DATA_W  loader word
//  ld_last      in   1       final word of the program
//  ld_err       out  1       sticky: out-of-range write or timeout seen; cleared by rst only
//  ld_count     out  ADDR_W  words written in the current/last load, saturating
//  dbg_req      in   1       debug read request (level; sampled in RUN only)
//  dbg_addr     in   ADDR_W  debug read address
//  dbg_ack      out  1       one-cycle pulse; dbg_data valid this cycle
//  dbg_data     out  DATA_W  registered debug read data
//  cpu_hold     out  1       freeze the pipeline (high in LOAD and FLUSH)
//  cpu_restart  out  1       one-cycle pulse; fetch must jump to PC 0
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_wren     out  1       memory write enable
//  mem_rdata    in   DATA_W  memory read data, 1-cycle synchronous latency
// BEHAVIOUR
//  Reset values
//  - state = RUN; all outputs 0 except fetch_stall = 1 and mem_addr = 0.
//  - The first cycle after rst deasserts is a normal RUN cycle.
//  RUN state
//  - Default: mem_addr = fetch_addr, mem_wren = 0.
//  - ld_valid has priority: if ld_valid = 1 -> LOAD next cycle.
//    - ld_ready = 0 in this cycle.
//    - fetch_stall = 1.
//    - ld_count is cleared.
//  - Else if dbg_req = 1:
//    - mem_addr = dbg_addr and fetch_stall = 1 for one cycle.
//    - Next cycle: dbg_data = mem_rdata and dbg_ack = 1; fetch resumes that cycle.
//    - At most one debug read per 2 cycles: dbg_req is ignored in the dbg_ack cycle.
//  LOAD state
//  - cpu_hold = 1, fetch_stall = 1, ld_ready = 1.
//  - mem_addr = ld_addr, mem_wdata = ld_data, mem_wren = ld_valid & (ld_addr < DEPTH).
//  - Accepted word with ld_addr >= DEPTH: no write, ld_err <= 1, ld_count does not increment.
//  - ld_count increments per written word and saturates at all-ones.
//  - Idle counter: cleared on every handshake. If it reaches TIMEOUT-1 with ld_valid still low:
//    ld_err <= 1 and -> FLUSH.
//  - Handshake with ld_last = 1 -> FLUSH.
//  FLUSH state (1 cycle)
//  - cpu_hold = 1, ld_ready = 0, mem_wren = 0, mem_addr = 0.
//  - This prefetches word 0 so it is valid in RESTART.
//  RESTART state (1 cycle)
//  - cpu_restart = 1, cpu_hold = 0, fetch_stall = 0, mem_addr = 0.
//  - -> RUN.
//  Simultaneous events
//  - ld_valid and dbg_req both high in RUN: load wins; the debug request stays pending and is
//    served after RESTART.
//  - ld_valid asserted in a dbg_ack cycle: the ack completes, then LOAD.
//  rst in any state
//  - Returns to RUN on the next edge; mem_wren = 0 in that edge's cycle.
//  - Any partial load is abandoned; ld_err and ld_count are cleared.
// STRUCTURE
//  - Shared package `cpu_defs`: state encoding, parameter defaults, instruction-memory width
//    constants.
//  - One sub-module, `imem_load_timer`: idle counter with clear and a `expired` output.
//  - Everything else (FSM, address/write mux, debug capture, counters) lives in imem_arbiter.
// TESTING
//  1. Reset, then RUN with fetch_addr = 5,6,7 -> mem_addr follows; fetch_stall = 0;
//     fetch_inst = mem[addr] one cycle later.
//  2. Load 3 words (0:0x1111, 1:0x2222, 2:0x3333; last on word 2) ->
//     - mem_wren high for 3 cycles;
//     - ld_count = 3; ld_err = 0;
//     - FLUSH, then cpu_restart pulses 1 cycle with mem_addr = 0.
//  3. Load word at addr DEPTH -> no write, ld_err = 1 and stays set; ld_count unchanged.
//  4. Start load, then hold ld_valid low for TIMEOUT cycles ->
//     ld_err = 1, FLUSH, RESTART, back in RUN.
//  5. dbg_req with addr 0x0002 (mem = 0x2222) ->
//     fetch_stall = 1 for 1 cycle; next cycle dbg_ack = 1 and dbg_data = 0x2222.
//  6. rst asserted mid-LOAD after 2 words ->
//     next cycle state = RUN, mem_wren = 0, ld_count = 0, cpu_hold = 0.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared CPU definitions: arbiter state encoding and instruction-memory defaults.
package cpu_defs;

  localparam int IMEM_ADDR_W  = 16;
  localparam int IMEM_DATA_W  = 16;
  localparam int IMEM_DEPTH   = 4096;
  localparam int IMEM_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_RESTART = 2'd3
  } arb_state_e;

  // Bits needed to count from 0 up to timeout-1.
  function automatic int timer_width(input int timeout);
    return (timeout < 3) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader, debug, CPU-control and memory-port signals around the arbiter.
interface imem_arbiter_if import cpu_defs::*; #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
);

  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_inst;
  logic              fetch_stall;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_err;
  logic [ADDR_W-1:0] ld_count;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;
  logic              cpu_hold;
  logic              cpu_restart;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_addr, ld_valid, ld_addr, ld_data, ld_last, dbg_req, dbg_addr, mem_rdata,
    output fetch_inst, fetch_stall, ld_ready, ld_err, ld_count, dbg_ack, dbg_data,
           cpu_hold, cpu_restart, mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output fetch_addr, ld_valid, ld_addr, ld_data, ld_last, dbg_req, dbg_addr, mem_rdata,
    input  fetch_inst, fetch_stall, ld_ready, ld_err, ld_count, dbg_ack, dbg_data,
           cpu_hold, cpu_restart, mem_addr, mem_wdata, mem_wren
  );

endinterface

// File: rtl/imem_arbiter_load_timer.sv
// Idle-cycle counter for program loads; expired holds once TIMEOUT-1 idle cycles are counted.
module imem_load_timer import cpu_defs::*; #(
  parameter int TIMEOUT = IMEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int CW = timer_width(TIMEOUT);

  logic [CW-1:0] count_reg;

  assign expired = (count_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: fetch, debug reads and sequenced program loads.
module imem_arbiter import cpu_defs::*; #(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int DATA_W  = IMEM_DATA_W,
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int TIMEOUT = IMEM_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  imem_arbiter_if.slave bus
);

  arb_state_e        state_reg;
  logic              cpu_hold_reg;
  logic              cpu_restart_reg;
  logic              dbg_ack_reg;
  logic [DATA_W-1:0] dbg_data_reg;
  logic              ld_err_reg;
  logic [ADDR_W-1:0] ld_count_reg;

  logic in_range;
  logic dbg_issue;
  logic timer_clear;
  logic timer_expired;

  assign in_range    = (32'(bus.ld_addr) < 32'(DEPTH));
  // The ack cycle never issues a new read, so debug reads are at most one per two cycles.
  assign dbg_issue   = (state_reg == ST_RUN) && !bus.ld_valid && bus.dbg_req && !dbg_ack_reg;
  assign timer_clear = (state_reg != ST_LOAD) || bus.ld_valid;

  imem_load_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  assign bus.fetch_inst  = rst ? '0 : bus.mem_rdata;
  assign bus.cpu_hold    = cpu_hold_reg;
  assign bus.cpu_restart = cpu_restart_reg;
  assign bus.dbg_ack     = dbg_ack_reg;
  assign bus.dbg_data    = dbg_ack_reg ? bus.mem_rdata : dbg_data_reg;
  assign bus.ld_err      = ld_err_reg;
  assign bus.ld_count    = ld_count_reg;

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wren    = 1'b0;
    bus.fetch_stall = 1'b1;
    bus.ld_ready    = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_RUN: begin
          bus.mem_addr    = dbg_issue ? bus.dbg_addr : bus.fetch_addr;
          bus.fetch_stall = bus.ld_valid || dbg_issue;
        end
        ST_LOAD: begin
          bus.mem_addr  = bus.ld_addr;
          bus.mem_wdata = bus.ld_data;
          bus.mem_wren  = bus.ld_valid && in_range;
          bus.ld_ready  = 1'b1;
        end
        ST_RESTART: begin
          bus.fetch_stall = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      cpu_hold_reg    <= 1'b0;
      cpu_restart_reg <= 1'b0;
      dbg_ack_reg     <= 1'b0;
      dbg_data_reg    <= '0;
      ld_err_reg      <= 1'b0;
      ld_count_reg    <= '0;
    end else begin
      cpu_restart_reg <= 1'b0;
      dbg_ack_reg     <= 1'b0;
      if (dbg_ack_reg) begin
        dbg_data_reg <= bus.mem_rdata;
      end
      case (state_reg)
        ST_RUN: begin
          if (bus.ld_valid) begin
            state_reg    <= ST_LOAD;
            cpu_hold_reg <= 1'b1;
            ld_count_reg <= '0;
          end else if (dbg_issue) begin
            dbg_ack_reg <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.ld_valid) begin
            if (!in_range) begin
              ld_err_reg <= 1'b1;
            end else if (ld_count_reg != '1) begin
              ld_count_reg <= ld_count_reg + 1'b1;
            end
            if (bus.ld_last) begin
              state_reg <= ST_FLUSH;
            end
          end else if (timer_expired) begin
            ld_err_reg <= 1'b1;
            state_reg  <= ST_FLUSH;
          end
        end
        // Word 0 is read during FLUSH so it is on mem_rdata in RESTART.
        ST_FLUSH: begin
          state_reg       <= ST_RESTART;
          cpu_hold_reg    <= 1'b0;
          cpu_restart_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

endmodule
